pe_gnt_enc_w512: RTL and testbench

Registered one-hot-to-binary grant encoder that sits directly downstream of the 512-bit simple priority encoder. It accepts the `Gnt`/`valid` pair, converts the one-hot grant to a 9-bit index, and buffers it in a 2-entry skid FIFO with a valid/ready handshake. It also maintains the programmable priority pointer (last issued index + 1), which upstream request-rotation logic uses to choose the next search start.

---
 rtl/pe_gnt_enc_w512.sv | 99 +++++++++
 tb/tb_pe_gnt_enc_w512.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pe_gnt_enc_w512.sv
// Registered one-hot-to-binary grant encoder with 2-entry skid FIFO and priority pointer.
// Define PE_ONEHOT_CHK_EN to add the sticky err_onehot one-hot violation flag.
module pe_gnt_enc_w512 #(
    parameter int WIDTH = 512,
    parameter int IDXW  = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] Gnt,
    input  logic             valid,
    output logic             ready,
    output logic [IDXW-1:0]  out_idx,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             ptr_load,
    input  logic [IDXW-1:0]  ptr_load_val,
    output logic [IDXW-1:0]  prio_ptr
`ifdef PE_ONEHOT_CHK_EN
    ,
    output logic             err_onehot
`endif
);

    // OR-based encode: a non-one-hot grant yields the OR of all set positions.
    function automatic logic [IDXW-1:0] enc_or(input logic [WIDTH-1:0] g);
        logic [IDXW-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            for (int k = 0; k < IDXW; k++) begin
                if (i[k]) r[k] = r[k] | g[i];
            end
        end
        return r;
    endfunction

    logic [IDXW-1:0] enc_idx;
    logic [IDXW-1:0] tail_idx;
    logic [1:0]      count;
    logic [1:0]      count_next;
    logic            push;
    logic            pop;

    assign enc_idx   = enc_or(Gnt);
    assign push      = valid && ready;
    assign pop       = out_valid && out_ready;
    assign out_valid = (count != 2'd0);

    always_comb begin
        count_next = count;
        if (push && !pop)      count_next = count + 2'd1;
        else if (pop && !push) count_next = count - 2'd1;
    end

    // out_idx is the head register itself; tail_idx holds the skid entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= 2'd0;
            ready    <= 1'b1;
            out_idx  <= '0;
            tail_idx <= '0;
        end else begin
            count <= count_next;
            ready <= (count_next < 2'd2);
            case (count)
                2'd0: begin
                    if (push) out_idx <= enc_idx;
                end
                2'd1: begin
                    if (push && pop) out_idx  <= enc_idx;
                    else if (push)   tail_idx <= enc_idx;
                end
                default: begin
                    if (pop) out_idx <= tail_idx;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_ptr <= '0;
        end else if (ptr_load) begin
            prio_ptr <= ptr_load_val;
        end else if (pop) begin
            prio_ptr <= out_idx + IDXW'(1);
        end
    end

`ifdef PE_ONEHOT_CHK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_onehot <= 1'b0;
        end else if (push && !$onehot(Gnt)) begin
            err_onehot <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pe_gnt_enc_w512.sv
// Directed self-checking bench for pe_gnt_enc_w512 (encoding, skid FIFO, pointer, reset).
module tb_pe_gnt_enc_w512;

    logic         clk;
    logic         rst_n;
    logic [511:0] Gnt;
    logic         valid;
    logic         ready;
    logic [8:0]   out_idx;
    logic         out_valid;
    logic         out_ready;
    logic         ptr_load;
    logic [8:0]   ptr_load_val;
    logic [8:0]   prio_ptr;
`ifdef PE_ONEHOT_CHK_EN
    logic         err_onehot;
`endif

    int checks = 0;
    int errors = 0;

    pe_gnt_enc_w512 #(.WIDTH(512), .IDXW(9)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .Gnt(Gnt),
        .valid(valid),
        .ready(ready),
        .out_idx(out_idx),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .ptr_load(ptr_load),
        .ptr_load_val(ptr_load_val),
        .prio_ptr(prio_ptr)
`ifdef PE_ONEHOT_CHK_EN
        ,
        .err_onehot(err_onehot)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout obs=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] bit_at(input int pos);
        logic [511:0] v;
        v = '0;
        v[pos] = 1'b1;
        return v;
    endfunction

    initial begin
        rst_n = 1'b0; Gnt = '0; valid = 1'b0; out_ready = 1'b0;
        ptr_load = 1'b0; ptr_load_val = '0;
        repeat (3) tick();
        chk("rst_ready", 16'(ready), 16'd1);
        chk("rst_out_valid", 16'(out_valid), 16'd0);
        chk("rst_out_idx", 16'(out_idx), 16'd0);
        chk("rst_prio_ptr", 16'(prio_ptr), 16'd0);
`ifdef PE_ONEHOT_CHK_EN
        chk("rst_err", 16'(err_onehot), 16'd0);
`endif
        rst_n = 1'b1;
        tick();

        // Single grant 37, immediate pop
        Gnt = bit_at(37); valid = 1'b1; out_ready = 1'b1;
        tick();
        valid = 1'b0;
        chk("g37_out_valid", 16'(out_valid), 16'd1);
        chk("g37_out_idx", 16'(out_idx), 16'd37);
        chk("g37_ready", 16'(ready), 16'd1);
        chk("g37_ptr_hold", 16'(prio_ptr), 16'd0);
        tick();
        chk("g37_ptr", 16'(prio_ptr), 16'd38);
        chk("g37_drained", 16'(out_valid), 16'd0);

        // Wrap at 511
        Gnt = bit_at(511); valid = 1'b1;
        tick();
        valid = 1'b0;
        chk("wrap_out_idx", 16'(out_idx), 16'd511);
        tick();
        chk("wrap_ptr", 16'(prio_ptr), 16'd0);

        // Backpressure: 5, 6, 7 offered with consumer stalled
        out_ready = 1'b0; Gnt = bit_at(5); valid = 1'b1;
        tick();
        chk("bp1_ready", 16'(ready), 16'd1);
        chk("bp1_out_idx", 16'(out_idx), 16'd5);
        Gnt = bit_at(6);
        tick();
        chk("bp2_ready", 16'(ready), 16'd0);
        chk("bp2_out_idx", 16'(out_idx), 16'd5);
        Gnt = bit_at(7);
        tick();
        chk("bp3_ready", 16'(ready), 16'd0);
        chk("bp3_out_idx", 16'(out_idx), 16'd5);
        chk("bp3_out_valid", 16'(out_valid), 16'd1);
        out_ready = 1'b1;
        tick();
        chk("bp4_out_idx", 16'(out_idx), 16'd6);
        chk("bp4_ready", 16'(ready), 16'd1);
        chk("bp4_ptr", 16'(prio_ptr), 16'd6);
        tick();
        valid = 1'b0;
        chk("bp5_out_idx", 16'(out_idx), 16'd7);
        chk("bp5_out_valid", 16'(out_valid), 16'd1);
        chk("bp5_ptr", 16'(prio_ptr), 16'd7);
        tick();
        chk("bp6_out_valid", 16'(out_valid), 16'd0);
        chk("bp6_ptr", 16'(prio_ptr), 16'd8);

        // Throughput with out_ready held high
        Gnt = bit_at(200); valid = 1'b1;
        tick();
        chk("tp1_out_idx", 16'(out_idx), 16'd200);
        Gnt = bit_at(201);
        tick();
        chk("tp2_out_idx", 16'(out_idx), 16'd201);
        chk("tp2_out_valid", 16'(out_valid), 16'd1);
        chk("tp2_ptr", 16'(prio_ptr), 16'd201);
        valid = 1'b0;
        tick();
        chk("tp3_ptr", 16'(prio_ptr), 16'd202);

        // Pop of 100 with simultaneous ptr_load of 300
        out_ready = 1'b0; Gnt = bit_at(100); valid = 1'b1;
        tick();
        valid = 1'b0;
        chk("pl_out_idx", 16'(out_idx), 16'd100);
        out_ready = 1'b1; ptr_load = 1'b1; ptr_load_val = 9'd300;
        tick();
        ptr_load = 1'b0;
        chk("pl_ptr", 16'(prio_ptr), 16'd300);
        chk("pl_drained", 16'(out_valid), 16'd0);
        ptr_load = 1'b1; ptr_load_val = 9'd123;
        tick();
        ptr_load = 1'b0;
        chk("load_only_ptr", 16'(prio_ptr), 16'd123);
        tick();
        chk("ptr_hold", 16'(prio_ptr), 16'd123);

        // Non-one-hot grants: OR-encoded
        out_ready = 1'b0; Gnt = 512'h3; valid = 1'b1;
        tick();
        valid = 1'b0;
        chk("g3_out_idx", 16'(out_idx), 16'd1);
`ifdef PE_ONEHOT_CHK_EN
        chk("g3_err", 16'(err_onehot), 16'd1);
`endif
        out_ready = 1'b1; Gnt = bit_at(3) | bit_at(12); valid = 1'b1;
        tick();
        chk("g3_12_out_idx", 16'(out_idx), 16'd15);
        Gnt = '0;
        tick();
        valid = 1'b0;
        chk("g0_out_idx", 16'(out_idx), 16'd0);
        chk("g0_out_valid", 16'(out_valid), 16'd1);
`ifdef PE_ONEHOT_CHK_EN
        chk("g0_err_sticky", 16'(err_onehot), 16'd1);
`endif
        tick();
        chk("g0_ptr", 16'(prio_ptr), 16'd1);

        // Asynchronous reset with a full FIFO
        out_ready = 1'b0; Gnt = bit_at(44); valid = 1'b1;
        tick();
        Gnt = bit_at(45);
        tick();
        valid = 1'b0;
        chk("full_ready", 16'(ready), 16'd0);
        ptr_load = 1'b1; ptr_load_val = 9'd77;
        tick();
        ptr_load = 1'b0;
        chk("full_ptr", 16'(prio_ptr), 16'd77);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 16'(out_valid), 16'd0);
        chk("arst_ready", 16'(ready), 16'd1);
        chk("arst_ptr", 16'(prio_ptr), 16'd0);
        chk("arst_out_idx", 16'(out_idx), 16'd0);
`ifdef PE_ONEHOT_CHK_EN
        chk("arst_err", 16'(err_onehot), 16'd0);
`endif
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("post_rst_empty", 16'(out_valid), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
